// File: rtl/syncff_ctrl.sv
// Single-clock FIFO controller driving an external dual-port RAM with a synchronous read port.
// Supports standard and first-word-fall-through modes, level thresholds, sticky errors and a high-watermark.
module syncff_ctrl #(
    parameter int unsigned ADDRB = 4,
    parameter bit          FWFT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             fifowr,
    input  logic             fiford,
    input  logic             fifoflush,
    input  logic             err_clr,
    input  logic [ADDRB:0]   afull_thr,
    input  logic [ADDRB:0]   aempty_thr,
    output logic             write,
    output logic [ADDRB-1:0] wraddr,
    output logic             read,
    output logic [ADDRB-1:0] rdaddr,
    output logic             dvalid,
    output logic             fifofull,
    output logic             fifoempty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ADDRB:0]   fifolen,
    output logic             ovf,
    output logic             unf,
    output logic [ADDRB:0]   maxlen
);

    localparam int unsigned PW = ADDRB + 1;

    // Head-word register state: only ever leaves HEAD_EMPTY in FWFT mode.
    typedef enum logic {
        HEAD_EMPTY = 1'b0,
        HEAD_VALID = 1'b1
    } head_state_e;

    head_state_e   head_q, head_d;
    logic [PW-1:0] wrpnt, wrpnt_d;
    logic [PW-1:0] rdpnt, rdpnt_d;
    logic [PW-1:0] ramcnt;
    logic [PW-1:0] maxlen_d;
    logic          ovf_d, unf_d;
    logic          ram_empty, ram_full;

    assign ramcnt    = wrpnt - rdpnt;
    assign ram_empty = (wrpnt == rdpnt);
    assign ram_full  = (wrpnt[ADDRB] != rdpnt[ADDRB]) &&
                       (wrpnt[ADDRB-1:0] == rdpnt[ADDRB-1:0]);

    assign wraddr       = wrpnt[ADDRB-1:0];
    assign rdaddr       = rdpnt[ADDRB-1:0];
    assign fifofull     = ram_full;
    assign dvalid       = (head_q == HEAD_VALID);
    assign almost_full  = (fifolen >= afull_thr);
    assign almost_empty = (fifolen <= aempty_thr);

    // RAM strobes and mode-dependent occupancy view; no RAM access while in reset.
    always_comb begin
        write     = fifowr & ~ram_full & ~fifoflush & rst_;
        read      = 1'b0;
        fifoempty = ram_empty;
        fifolen   = ramcnt;
        if (FWFT) begin
            read      = ~ram_empty & (~dvalid | fiford) & ~fifoflush & rst_;
            fifoempty = ~dvalid;
            fifolen   = ramcnt + PW'(dvalid);
        end else begin
            read      = fiford & ~ram_empty & ~fifoflush & rst_;
        end
    end

    // Next-state for pointers, head register, sticky flags and watermark.
    always_comb begin
        wrpnt_d  = wrpnt;
        rdpnt_d  = rdpnt;
        head_d   = head_q;
        ovf_d    = ovf;
        unf_d    = unf;
        maxlen_d = (fifolen > maxlen) ? fifolen : maxlen;

        if (fifoflush) begin
            wrpnt_d = '0;
            rdpnt_d = '0;
        end else begin
            if (write) wrpnt_d = wrpnt + PW'(1);
            if (read)  rdpnt_d = rdpnt + PW'(1);
        end

        if (FWFT) begin
            if (fifoflush)   head_d = HEAD_EMPTY;
            else if (read)   head_d = HEAD_VALID;
            else if (fiford) head_d = HEAD_EMPTY;
        end else begin
            head_d = HEAD_EMPTY;
        end

        // Setting an error wins over a clear in the same cycle.
        if (err_clr) begin
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
            maxlen_d = fifolen;
        end
        if (fifowr & fifofull & ~fifoflush)  ovf_d = 1'b1;
        if (fiford & fifoempty & ~fifoflush) unf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wrpnt  <= '0;
            rdpnt  <= '0;
            head_q <= HEAD_EMPTY;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            maxlen <= '0;
        end else begin
            wrpnt  <= wrpnt_d;
            rdpnt  <= rdpnt_d;
            head_q <= head_d;
            ovf    <= ovf_d;
            unf    <= unf_d;
            maxlen <= maxlen_d;
        end
    end

endmodule

// File: tb/tb_syncff_ctrl.sv
// Directed bench for syncff_ctrl: one standard-mode and one FWFT instance, both with ADDRB=2.
module tb_syncff_ctrl;

    localparam int unsigned AB = 2;

    logic          clk = 1'b0;
    logic          rst_;
    logic [AB:0]   afull_thr, aempty_thr;

    logic          s_wr, s_rd, s_fl, s_clr;
    logic          s_write, s_read, s_dvalid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;
    logic [AB-1:0] s_wraddr, s_rdaddr;
    logic [AB:0]   s_len, s_maxlen;

    logic          f_wr, f_rd, f_fl, f_clr;
    logic          f_write, f_read, f_dvalid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
    logic [AB-1:0] f_wraddr, f_rdaddr;
    logic [AB:0]   f_len, f_maxlen;

    int nchk = 0;
    int nerr = 0;
    int exp_wr;
    int exp_rd;
    int q[$];

    always #5 clk = ~clk;

    syncff_ctrl #(.ADDRB(AB), .FWFT(1'b0)) u_std (
        .clk(clk), .rst_(rst_), .fifowr(s_wr), .fiford(s_rd), .fifoflush(s_fl), .err_clr(s_clr),
        .afull_thr(afull_thr), .aempty_thr(aempty_thr),
        .write(s_write), .wraddr(s_wraddr), .read(s_read), .rdaddr(s_rdaddr), .dvalid(s_dvalid),
        .fifofull(s_full), .fifoempty(s_empty), .almost_full(s_afull), .almost_empty(s_aempty),
        .fifolen(s_len), .ovf(s_ovf), .unf(s_unf), .maxlen(s_maxlen)
    );

    syncff_ctrl #(.ADDRB(AB), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst_(rst_), .fifowr(f_wr), .fiford(f_rd), .fifoflush(f_fl), .err_clr(f_clr),
        .afull_thr(afull_thr), .aempty_thr(aempty_thr),
        .write(f_write), .wraddr(f_wraddr), .read(f_read), .rdaddr(f_rdaddr), .dvalid(f_dvalid),
        .fifofull(f_full), .fifoempty(f_empty), .almost_full(f_afull), .almost_empty(f_aempty),
        .fifolen(f_len), .ovf(f_ovf), .unf(f_unf), .maxlen(f_maxlen)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic s_set(input logic wr, input logic rd, input logic fl, input logic clr);
        s_wr = wr; s_rd = rd; s_fl = fl; s_clr = clr;
    endtask

    task automatic f_set(input logic wr, input logic rd, input logic fl, input logic clr);
        f_wr = wr; f_rd = rd; f_fl = fl; f_clr = clr;
    endtask

    initial begin
        rst_ = 1'b1;
        afull_thr = 3'd3;
        aempty_thr = 3'd1;
        s_set(0, 0, 0, 0);
        f_set(0, 0, 0, 0);
        #1 rst_ = 1'b0;
        #1;
        // Reset state
        chk("rst_s_write", 32'(s_write), 0);
        chk("rst_s_read", 32'(s_read), 0);
        chk("rst_s_full", 32'(s_full), 0);
        chk("rst_s_empty", 32'(s_empty), 1);
        chk("rst_s_aempty", 32'(s_aempty), 1);
        chk("rst_s_afull", 32'(s_afull), 0);
        chk("rst_s_len", 32'(s_len), 0);
        chk("rst_s_maxlen", 32'(s_maxlen), 0);
        chk("rst_f_dvalid", 32'(f_dvalid), 0);
        chk("rst_f_empty", 32'(f_empty), 1);
        afull_thr = 3'd0;
        #1;
        chk("rst_afull_thr0", 32'(s_afull), 1);
        afull_thr = 3'd3;
        tick();
        rst_ = 1'b1;
        tick();

        // Standard mode: fill to full with threshold checks
        for (int i = 0; i < 4; i++) begin
            s_set(1, 0, 0, 0);
            #1;
            chk("s_fill_write", 32'(s_write), 1);
            chk("s_fill_wraddr", 32'(s_wraddr), 32'(i));
            tick();
            chk("s_fill_len", 32'(s_len), 32'(i + 1));
            chk("s_fill_afull", 32'(s_afull), 32'((i + 1) >= 3));
            chk("s_fill_aempty", 32'(s_aempty), 32'((i + 1) <= 1));
            chk("s_fill_full", 32'(s_full), 32'(i == 3));
        end
        chk("s_dvalid_tied", 32'(s_dvalid), 0);
        #1;
        chk("s_ovf_write_blocked", 32'(s_write), 0);
        tick();
        chk("s_ovf_set", 32'(s_ovf), 1);
        chk("s_ovf_len", 32'(s_len), 4);
        chk("s_maxlen4", 32'(s_maxlen), 4);

        // Flush keeps sticky state
        s_set(1, 0, 1, 0);
        #1;
        chk("s_flush_write", 32'(s_write), 0);
        tick();
        s_set(0, 0, 0, 0);
        chk("s_flush_len", 32'(s_len), 0);
        chk("s_flush_empty", 32'(s_empty), 1);
        chk("s_flush_maxlen", 32'(s_maxlen), 4);
        chk("s_flush_ovf", 32'(s_ovf), 1);

        s_set(0, 0, 0, 1);
        tick();
        chk("s_clr_ovf", 32'(s_ovf), 0);
        chk("s_clr_maxlen", 32'(s_maxlen), 0);

        // Refill, then simultaneous read+write while full
        s_set(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("s_refill_wraddr", 32'(s_wraddr), 32'(i));
            tick();
        end
        chk("s_refill_full", 32'(s_full), 1);
        s_set(1, 1, 0, 0);
        #1;
        chk("s_fullrw_read", 32'(s_read), 1);
        chk("s_fullrw_write", 32'(s_write), 0);
        chk("s_fullrw_rdaddr", 32'(s_rdaddr), 0);
        tick();
        chk("s_fullrw_len", 32'(s_len), 3);
        chk("s_fullrw_ovf", 32'(s_ovf), 1);
        s_set(0, 0, 0, 1);
        tick();
        chk("s_clr2_ovf", 32'(s_ovf), 0);
        chk("s_clr2_maxlen", 32'(s_maxlen), 3);

        // Drain, then underflow cases
        s_set(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("s_drain_read", 32'(s_read), 1);
            chk("s_drain_rdaddr", 32'(s_rdaddr), 32'(i + 1));
            tick();
            chk("s_drain_len", 32'(s_len), 32'(2 - i));
        end
        chk("s_drain_empty", 32'(s_empty), 1);
        s_set(0, 1, 0, 1);
        #1;
        chk("s_unf_read", 32'(s_read), 0);
        tick();
        chk("s_unf_over_clr", 32'(s_unf), 1);
        s_set(1, 1, 0, 0);
        #1;
        chk("s_emptyrw_write", 32'(s_write), 1);
        chk("s_emptyrw_read", 32'(s_read), 0);
        tick();
        chk("s_emptyrw_len", 32'(s_len), 1);

        // Streaming pairs across pointer wrap, address order checked against a queue
        q.push_back(0);
        exp_wr = 5;
        for (int i = 0; i < 20; i++) begin
            s_set(1, 1, 0, 0);
            #1;
            chk("s_wrap_write", 32'(s_write), 1);
            chk("s_wrap_read", 32'(s_read), 1);
            chk("s_wrap_wraddr", 32'(s_wraddr), 32'(exp_wr % 4));
            exp_rd = q.pop_front();
            chk("s_wrap_rdaddr", 32'(s_rdaddr), 32'(exp_rd));
            q.push_back(exp_wr % 4);
            tick();
            exp_wr++;
            chk("s_wrap_len", 32'(s_len), 1);
            chk("s_wrap_full", 32'(s_full), 0);
            chk("s_wrap_empty", 32'(s_empty), 0);
        end

        // Asynchronous reset mid-stream with requests still asserted
        #2 rst_ = 1'b0;
        #1;
        chk("s_arst_write", 32'(s_write), 0);
        chk("s_arst_read", 32'(s_read), 0);
        chk("s_arst_len", 32'(s_len), 0);
        chk("s_arst_empty", 32'(s_empty), 1);
        chk("s_arst_unf", 32'(s_unf), 0);
        chk("s_arst_wraddr", 32'(s_wraddr), 0);
        chk("s_arst_maxlen", 32'(s_maxlen), 0);
        s_set(0, 0, 0, 0);
        tick();
        rst_ = 1'b1;
        tick();

        // FWFT: single write latency and consume
        f_set(1, 0, 0, 0);
        #1;
        chk("f_first_write", 32'(f_write), 1);
        chk("f_first_noread", 32'(f_read), 0);
        tick();
        f_set(0, 0, 0, 0);
        #1;
        chk("f_t1_read", 32'(f_read), 1);
        chk("f_t1_dvalid", 32'(f_dvalid), 0);
        chk("f_t1_len", 32'(f_len), 1);
        tick();
        chk("f_t2_dvalid", 32'(f_dvalid), 1);
        chk("f_t2_len", 32'(f_len), 1);
        chk("f_t2_empty", 32'(f_empty), 0);
        chk("f_t2_read", 32'(f_read), 0);
        f_set(0, 1, 0, 0);
        tick();
        f_set(0, 0, 0, 0);
        chk("f_pop_dvalid", 32'(f_dvalid), 0);
        chk("f_pop_empty", 32'(f_empty), 1);
        chk("f_pop_len", 32'(f_len), 0);
        chk("f_pop_unf", 32'(f_unf), 0);
        f_set(0, 1, 0, 0);
        tick();
        f_set(0, 0, 0, 1);
        chk("f_unf_set", 32'(f_unf), 1);
        tick();
        chk("f_unf_clr", 32'(f_unf), 0);

        // FWFT capacity is RAM depth plus the head word
        f_set(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("f_cap_read", 32'(f_read), 32'(i == 1));
            tick();
            chk("f_cap_len", 32'(f_len), 32'(i + 1));
            chk("f_cap_full", 32'(f_full), 32'(i == 4));
        end
        #1;
        chk("f_cap_write_blocked", 32'(f_write), 0);
        tick();
        chk("f_cap_ovf", 32'(f_ovf), 1);
        chk("f_cap_len5", 32'(f_len), 5);
        chk("f_cap_maxlen", 32'(f_maxlen), 5);
        f_set(1, 1, 0, 0);
        #1;
        chk("f_fullrw_read", 32'(f_read), 1);
        chk("f_fullrw_write", 32'(f_write), 0);
        tick();
        chk("f_fullrw_len", 32'(f_len), 4);
        f_set(0, 0, 1, 0);
        #1;
        chk("f_flush_read", 32'(f_read), 0);
        tick();
        f_set(0, 0, 0, 0);
        chk("f_flush_len", 32'(f_len), 0);
        chk("f_flush_dvalid", 32'(f_dvalid), 0);
        chk("f_flush_ovf", 32'(f_ovf), 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
